// File: rtl/alu_pkg.sv
// Shared opcode, flag and FSM encodings for the ALU issue controller.
// The top controller and the register file both import this package.
package alu_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_NREGS  = 16;
    localparam int FLAG_W     = 5;

    // OpHi values: register forms and immediate forms
    localparam logic [3:0] OPHI_REG   = 4'b0000;
    localparam logic [3:0] OPHI_ADDI  = 4'b0101;
    localparam logic [3:0] OPHI_ADDUI = 4'b0110;
    localparam logic [3:0] OPHI_ADDCI = 4'b0111;
    localparam logic [3:0] OPHI_REG2  = 4'b1000;
    localparam logic [3:0] OPHI_SUBI  = 4'b1001;
    localparam logic [3:0] OPHI_CMPI  = 4'b1011;

    // OpExt values
    localparam logic [3:0] OPX_LSHI  = 4'b0000;
    localparam logic [3:0] OPX_AND   = 4'b0001;
    localparam logic [3:0] OPX_OR    = 4'b0010;
    localparam logic [3:0] OPX_XOR   = 4'b0011;
    localparam logic [3:0] OPX_NOT   = 4'b0100;
    localparam logic [3:0] OPX_LSH   = 4'b0100;
    localparam logic [3:0] OPX_ADD   = 4'b0101;
    localparam logic [3:0] OPX_ADDU  = 4'b0110;
    localparam logic [3:0] OPX_ADDC  = 4'b0111;
    localparam logic [3:0] OPX_ADDCU = 4'b1000;
    localparam logic [3:0] OPX_SUB   = 4'b1001;
    localparam logic [3:0] OPX_CMP   = 4'b1011;
    localparam logic [3:0] OPX_CMPU  = 4'b1111;

    // Flag bit positions inside {Z,C,F,N,L}
    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_L = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    function automatic logic is_reg_form(input logic [3:0] ophi);
        return (ophi == OPHI_REG) || (ophi == OPHI_REG2);
    endfunction

    function automatic logic is_imm_form(input logic [3:0] ophi);
        return (ophi == OPHI_ADDI) || (ophi == OPHI_ADDUI) || (ophi == OPHI_ADDCI) ||
               (ophi == OPHI_SUBI) || (ophi == OPHI_CMPI);
    endfunction

    function automatic logic is_compare(input logic [3:0] ophi, input logic [3:0] opext);
        return ((ophi == OPHI_REG) && ((opext == OPX_CMP) || (opext == OPX_CMPU))) ||
               (ophi == OPHI_CMPI);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// General-purpose register file: two async operand reads, one async debug
// read, one synchronous write port, all registers cleared by reset.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int NREGS  = ALU_NREGS,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs_reg [NREGS];
    logic [NREGS-1:0]  wsel;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_wsel
            assign wsel[gi] = we && (wa == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wsel[i]) begin
                    regs_reg[i] <= wd;
                end
            end
        end
    end

    assign ra_data  = regs_reg[ra_addr];
    assign rb_data  = regs_reg[rb_addr];
    assign dbg_data = regs_reg[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Non-pipelined issue controller for the external ALU: accept, read operands,
// execute, write back. One instruction every four cycles.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int NREGS  = ALU_NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_inst,
    output logic [7:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [FLAG_W-1:0] psr,
    output logic              done,
    output logic              err,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int AW = $clog2(NREGS);

    logic [1:0]        state_reg, state_next;
    logic [15:0]       inst_reg;
    logic              bad_reg;
    logic [7:0]        alu_op_reg;
    logic [DATA_W-1:0] alu_a_reg, alu_b_reg;
    logic [DATA_W-1:0] c_reg;
    logic [FLAG_W-1:0] flags_reg;
    logic [FLAG_W-1:0] psr_reg;
    logic              done_reg, err_reg;

    logic [3:0]        ophi, opext;
    logic [AW-1:0]     rd_addr, rs_addr;
    logic [DATA_W-1:0] rd_data, rs_data, imm_ext;
    logic              rf_we;

    assign ophi    = inst_reg[15:12];
    assign opext   = inst_reg[7:4];
    assign rd_addr = inst_reg[8 +: AW];
    assign rs_addr = inst_reg[0 +: AW];
    assign imm_ext = {{(DATA_W-8){inst_reg[7]}}, inst_reg[7:0]};

    // Compares only update the status flags, never a register.
    assign rf_we = (state_reg == ST_WB) && !bad_reg && !is_compare(ophi, opext);

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (rd_addr),
        .ra_data  (rd_data),
        .rb_addr  (rs_addr),
        .rb_data  (rs_data),
        .dbg_addr (dbg_addr[AW-1:0]),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .wa       (rd_addr),
        .wd       (c_reg)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid) state_next = ST_READ;
            ST_READ: state_next = ST_EXEC;
            ST_EXEC: state_next = ST_WB;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            inst_reg   <= '0;
            bad_reg    <= 1'b0;
            alu_op_reg <= '0;
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
            c_reg      <= '0;
            flags_reg  <= '0;
            psr_reg    <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            // done/err are registered so they are high exactly during WB
            done_reg  <= (state_reg == ST_EXEC);
            err_reg   <= (state_reg == ST_EXEC) && bad_reg;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) inst_reg <= in_inst;
                end
                ST_READ: begin
                    alu_op_reg <= {ophi, opext};
                    alu_a_reg  <= rd_data;
                    alu_b_reg  <= is_imm_form(ophi) ? imm_ext : rs_data;
                    bad_reg    <= !(is_reg_form(ophi) || is_imm_form(ophi));
                end
                ST_EXEC: begin
                    c_reg     <= alu_c;
                    flags_reg <= alu_flags;
                end
                default: begin
                    if (!bad_reg) psr_reg <= flags_reg;
                end
            endcase
        end
    end

    assign in_ready = (state_reg == ST_IDLE);
    assign alu_op   = alu_op_reg;
    assign alu_a    = alu_a_reg;
    assign alu_b    = alu_b_reg;
    assign psr      = psr_reg;
    assign done     = done_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with a behavioural ALU
// attached to the alu_* ports and an instruction-level reference model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_inst = '0;
    logic [7:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [4:0]  alu_flags;
    logic [4:0]  psr;
    logic        done, err;
    logic [3:0]  dbg_addr = '0;
    logic [15:0] dbg_data;
    logic [20:0] alu_res;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int done_cnt = 0;

    logic [15:0] mreg [16];
    logic [4:0]  mpsr;

    always #20 clk = ~clk;

    alu_issue_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .alu_flags (alu_flags),
        .psr       (psr),
        .done      (done),
        .err       (err),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    // Behavioural ALU: returns {Z,C,F,N,L, C[15:0]}
    function automatic logic [20:0] alu_fn(input logic [7:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [16:0] wide;
        logic [15:0] c;
        logic        cy, ov;
        logic        is_sub;
        is_sub = 1'b0;
        cy = 1'b0;
        ov = 1'b0;
        case (op[7:4])
            4'b0000: begin
                case (op[3:0])
                    4'b0001: c = a & b;
                    4'b0010: c = a | b;
                    4'b0011: c = a ^ b;
                    4'b0100: c = ~a;
                    4'b0000: c = a << b[3:0];
                    4'b0101, 4'b0110, 4'b0111, 4'b1000: c = a + b;
                    4'b1001, 4'b1011, 4'b1111: begin c = a - b; is_sub = 1'b1; end
                    default: c = a;
                endcase
            end
            4'b0101, 4'b0110, 4'b0111, 4'b1000: c = a + b;
            4'b1001, 4'b1011: begin c = a - b; is_sub = 1'b1; end
            default: c = a;
        endcase
        if (is_sub) begin
            wide = {1'b0, a} - {1'b0, b};
            cy = wide[16];
            ov = (a[15] != b[15]) && (c[15] != a[15]);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            cy = wide[16];
            ov = (a[15] == b[15]) && (c[15] != a[15]);
        end
        return {(c == 16'h0), cy, ov, c[15], (a < b), c};
    endfunction

    assign alu_res   = alu_fn(alu_op, alu_a, alu_b);
    assign alu_c     = alu_res[15:0];
    assign alu_flags = alu_res[20:16];

    always @(posedge clk) begin
        if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic supported(input logic [3:0] ophi);
        return ophi inside {4'b0000, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1011};
    endfunction

    // Architectural effect of one instruction on the model state.
    task automatic model_exec(input logic [15:0] inst);
        logic [3:0]  ophi, opx, rd, rs;
        logic [15:0] b;
        logic [20:0] r;
        logic        cmp;
        ophi = inst[15:12];
        rd   = inst[11:8];
        opx  = inst[7:4];
        rs   = inst[3:0];
        b    = (ophi == 4'b0000 || ophi == 4'b1000) ? mreg[rs] : {{8{inst[7]}}, inst[7:0]};
        r    = alu_fn({ophi, opx}, mreg[rd], b);
        cmp  = (ophi == 4'b1011) || (ophi == 4'b0000 && (opx == 4'b1011 || opx == 4'b1111));
        if (supported(ophi)) begin
            if (!cmp) mreg[rd] = r[15:0];
            mpsr = r[20:16];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mreg[i] = '0;
        mpsr = '0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [15:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    // Called at posedge+1 in IDLE; sweeps all registers within one clock phase.
    task automatic check_state(input string tag);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), v);
            check($sformatf("%s_R%0d", tag, i), 32'(v), 32'(mreg[i]));
        end
        check({tag, "_psr"}, 32'(psr), 32'(mpsr));
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_inst(input logic [15:0] inst);
        int  n;
        logic exp_err;
        exp_err = !supported(inst[15:12]);
        @(posedge clk); #1;
        wait_ready("run");
        in_valid = 1'b1;
        in_inst  = inst;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!done && n < 8) begin
            check("busy_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        // accept cycle counts as the first of four: done lands three edges later
        check("done_latency", 32'(n), 32'd3);
        check("done_ready", 32'(in_ready), 32'd0);
        check("err", 32'(err), 32'(exp_err));
        $display("inst %h retired after %0d edges err=%b", inst, n, err);
        model_exec(inst);
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd0);
        check_state("post");
    endtask

    task automatic stream(input int count);
        int acc0, done0;
        logic [15:0] inst;
        acc0 = acc_cnt;
        done0 = done_cnt;
        @(posedge clk); #1;
        wait_ready("stream");
        in_valid = 1'b1;
        for (int k = 0; k < count; k++) begin
            inst = {4'b0101, 4'(k + 4), 8'($urandom_range(0, 255))};
            in_inst = inst;
            check("stream_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            for (int j = 1; j <= 3; j++) begin
                check("stream_busy", 32'(in_ready), 32'd0);
                if (j == 3) check("stream_done", 32'(done), 32'd1);
                @(posedge clk); #1;
            end
            $display("stream inst %h accepted", inst);
            model_exec(inst);
        end
        in_valid = 1'b0;
        check("stream_accepts", 32'(acc_cnt - acc0), 32'(count));
        check("stream_dones", 32'(done_cnt - done0), 32'(count));
        check_state("stream");
    endtask

    initial begin
        logic [15:0] v;
        int dc0;
        model_reset();
        #90 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_op", 32'(alu_op), 32'd0);
        check("rst_a", 32'(alu_a), 32'd0);
        check("rst_b", 32'(alu_b), 32'd0);
        check_state("rst");

        run_inst(16'h5105);
        read_reg(4'd1, v);
        check("addi_r1", 32'(v), 32'h0005);
        check("addi_z", 32'(psr[4]), 32'd0);
        run_inst(16'h52FF);
        read_reg(4'd2, v);
        check("addi_neg_r2", 32'(v), 32'hFFFF);
        run_inst(16'h0152);
        read_reg(4'd1, v);
        check("add_r1", 32'(v), 32'h0004);
        check("add_psr", 32'(psr), 32'(5'b01001));
        run_inst(16'h01B1);
        read_reg(4'd1, v);
        check("cmp_r1", 32'(v), 32'h0004);
        check("cmp_psr", 32'(psr), 32'(5'b10000));
        run_inst(16'hF000);

        for (int k = 0; k < 40; k++) begin
            run_inst(16'($urandom));
        end

        stream(5);

        // reset during EXEC must abandon the instruction
        @(posedge clk); #1;
        wait_ready("rst_mid");
        in_valid = 1'b1;
        in_inst  = 16'h5307;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        dc0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst_done", 32'(done), 32'd0);
        #3 rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("midrst_ready", 32'(in_ready), 32'd1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("midrst_nodone", 32'(done_cnt - dc0), 32'd0);
        read_reg(4'd3, v);
        check("midrst_r3", 32'(v), 32'h0000);
        check_state("midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Drives the 16-bit ALU: accepts one 16-bit instruction per handshake, decodes it, and reads operands from an internal 16x16 register file.
- Presents {Opcode, A, B} to the external combinational ALU, captures C and the 5-bit ZCFNL flags, then writes back the result and the processor status flags.
- Multi-cycle and non-pipelined; sits between instruction fetch and the ALU in the datapath.

Parameters:
- DATA_W, 16, operand/result/register width
- NREGS, 16, register count; register address is log2(NREGS) = 4 bits

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept an instruction
- in_inst  in  16  instruction: [15:12] OpHi, [11:8] Rdest, [7:4] OpExt, [3:0] Rsrc/imm-low
- alu_op  out  8  Opcode to ALU
- alu_a  out  16  ALU operand A
- alu_b  out  16  ALU operand B
- alu_c  in  16  ALU result
- alu_flags  in  5  ALU flags {Z,C,F,N,L}
- psr  out  5  latched status flags {Z,C,F,N,L}
- done  out  1  one-cycle pulse: instruction retired
- err  out  1  one-cycle pulse, coincident with done: unsupported OpHi
- dbg_addr  in  4  register-file debug read address
- dbg_data  out  16  R[dbg_addr], combinational

Behaviour:
- Reset (asynchronous, active-low):
  - all registers R0..R15 = 0; psr = 0; alu_op/alu_a/alu_b = 0; done = err = 0
  - state = IDLE; in_ready = 1 once reset is released
- States: IDLE -> READ -> EXEC -> WB -> IDLE. Accept-to-done latency is exactly 4 cycles; throughput is 1 instruction per 4 cycles.
- IDLE:
  - in_ready = 1
  - on in_valid & in_ready, latch in_inst and go to READ
  - in_valid with no acceptance has no effect
- READ:
  - alu_op <= {OpHi, OpExt}
  - alu_a <= R[Rdest]
  - alu_b <= R[Rsrc] for register forms (OpHi 0000, 1000)
  - alu_b <= sign-extended {OpExt, Rsrc} (imm8) for immediate forms (0101 ADDI, 0110 ADDUI, 0111 ADDCI, 1001 SUBI, 1011 CMPI)
  - any other OpHi sets an internal bad flag
- EXEC:
  - alu_* outputs are held stable for the whole cycle
  - at cycle end, capture alu_c and alu_flags into internal registers
- WB:
  - if not bad: R[Rdest] <= captured C, except for compares (OpHi 0000 with OpExt 1011 CMP or 1111 CMPU; OpHi 1011 CMPI), which write no register
  - if not bad: psr <= captured flags for every supported instruction, compares included
  - if bad: no register write, no psr change, err = 1
  - done = 1 in all cases; return to IDLE
- in_ready is 0 in READ, EXEC and WB. An instruction is never accepted on the cycle done is high; the earliest next acceptance is the following IDLE cycle.
- Rdest == Rsrc: both operands read the same pre-write value.
- Reset mid-instruction: the instruction is abandoned, with no writeback, no psr update and no done.
- The block never modifies alu_c or alu_flags semantics; arithmetic and flags are defined solely by the ALU. All widths are exact, and the register address wraps naturally at 4 bits.
- dbg_data reflects the write on the cycle after WB.

Decomposition:
- Shared package (alu_pkg): OpHi/OpExt constants (AND 0001, OR 0010, XOR 0011, NOT 0100, ADD 0101, ADDU 0110, ADDC 0111, ADDCU 1000, SUB 1001, CMP 1011, CMPU 1111, LSHI 0000, LSH 0100; immediate OpHi values listed above), flag bit indices (Z=4, C=3, F=2, N=1, L=0), and the FSM state encoding.
- Sub-module: alu_regfile (16x16, two async read ports plus one debug read, one sync write port, async reset to zero).

Test Plan:
- Bench instantiates the real ALU, connected through alu_* ports.
- Reset release, then inst 0x5105 (ADDI R1,#5) -> done at accept+4 cycles, R1 = 0x0005, psr Z = 0.
- Inst 0x52FF (ADDI R2,#-1) -> R2 = 0xFFFF. Then 0x0152 (ADD R1,R2) -> R1 = 0x0004, psr equals the ALU flags for 5 + 0xFFFF.
- Inst 0x01B1 (CMP R1,R1) -> R1 unchanged (0x0004), psr updated from the ALU (Z per ALU), done = 1, err = 0.
- Inst 0xF000 -> done and err pulse together; R0 through R15 and psr unchanged.
- in_valid held high continuously with distinct instructions -> in_ready low for 3 cycles after each accept, exactly one accept per 4 cycles, no instruction dropped or duplicated.
- Assert rst_n low during EXEC of 0x5307 -> R3 = 0, psr = 0, no done pulse, in_ready = 1 after release.
